// File: rtl/wb2axil_pkg.sv
// Shared types and AXI response codes for the Wishbone to AXI4-Lite bridge.
// The FSM state enum lives here so the bridge and any wrapper agree on encodings.
package wb2axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } wb2axil_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything other than plain OKAY terminates the Wishbone cycle with err.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp inside {RESP_EXOKAY, RESP_SLVERR, RESP_DECERR};
    endfunction

endpackage

// File: rtl/wb2axi4l_bridge.sv
// Wishbone classic single-beat slave to AXI4-Lite master bridge.
// One transaction in flight; every output is driven from a register.
module wb2axi4l_bridge
    import wb2axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH-1:0] m_aw_addr,
    output logic [2:0]            m_aw_prot,
    output logic                  m_aw_valid,
    input  logic                  m_aw_ready,
    output logic [DATA_WIDTH-1:0] m_w_data,
    output logic [3:0]            m_w_strb,
    output logic                  m_w_valid,
    input  logic                  m_w_ready,
    input  logic [1:0]            m_b_resp,
    input  logic                  m_b_valid,
    output logic                  m_b_ready,
    output logic [ADDR_WIDTH-1:0] m_ar_addr,
    output logic [2:0]            m_ar_prot,
    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    input  logic [DATA_WIDTH-1:0] m_r_data,
    input  logic [1:0]            m_r_resp,
    input  logic                  m_r_valid,
    output logic                  m_r_ready
);

    wb2axil_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]            strb_q, strb_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  r_ready_q, r_ready_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  aw_done;
    logic                  w_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            strb_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            strb_q     <= strb_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            b_ready_q  <= b_ready_d;
            r_ready_q  <= r_ready_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !aw_valid_q || m_aw_ready;
    assign w_done  = !w_valid_q || m_w_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        strb_d     = strb_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        b_ready_d  = b_ready_q;
        r_ready_d  = r_ready_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The ack/err guard keeps the pulse cycle from re-launching.
                if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
                    addr_d  = wb_adr_i;
                    wdata_d = wb_dat_i;
                    strb_d  = wb_sel_i;
                    if (wb_we_i) begin
                        state_d    = WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD_REQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (aw_valid_q && m_aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && m_w_ready)   w_valid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d   = WR_RESP;
                    b_ready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_b_valid) begin
                    state_d   = IDLE;
                    b_ready_d = 1'b0;
                    ack_d     = wb_cyc_i && !resp_is_err(m_b_resp);
                    err_d     = wb_cyc_i && resp_is_err(m_b_resp);
                end
            end
            RD_REQ: begin
                if (m_ar_ready) begin
                    state_d    = RD_RESP;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (m_r_valid) begin
                    state_d   = IDLE;
                    r_ready_d = 1'b0;
                    rdata_d   = m_r_data;
                    ack_d     = wb_cyc_i && !resp_is_err(m_r_resp);
                    err_d     = wb_cyc_i && resp_is_err(m_r_resp);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_dat_o   = rdata_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign m_aw_addr  = addr_q;
    assign m_aw_prot  = AXI_PROT;
    assign m_aw_valid = aw_valid_q;
    assign m_w_data   = wdata_q;
    assign m_w_strb   = strb_q;
    assign m_w_valid  = w_valid_q;
    assign m_b_ready  = b_ready_q;
    assign m_ar_addr  = addr_q;
    assign m_ar_prot  = AXI_PROT;
    assign m_ar_valid = ar_valid_q;
    assign m_r_ready  = r_ready_q;

endmodule

// File: tb/tb_wb2axi4l_bridge.sv
// Scoreboard bench for wb2axi4l_bridge with a configurable-delay AXI4-Lite slave.
// Expected WB terminations and AXI beats are queued at launch and popped on output.
module tb_wb2axi4l_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] m_aw_addr;
    logic [2:0]  m_aw_prot;
    logic        m_aw_valid;
    logic        m_aw_ready;
    logic [31:0] m_w_data;
    logic [3:0]  m_w_strb;
    logic        m_w_valid;
    logic        m_w_ready;
    logic [1:0]  m_b_resp;
    logic        m_b_valid;
    logic        m_b_ready;
    logic [31:0] m_ar_addr;
    logic [2:0]  m_ar_prot;
    logic        m_ar_valid;
    logic        m_ar_ready;
    logic [31:0] m_r_data;
    logic [1:0]  m_r_resp;
    logic        m_r_valid;
    logic        m_r_ready;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int n_term = 0;
    int n_rhs = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_v = 2'b00;
    logic [1:0]  r_resp_v = 2'b00;
    logic [31:0] r_data_v = '0;

    typedef struct {
        bit          err;
        logic [31:0] dat;
        int          t0;
        bit          lat;
    } sb_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    sb_t         sb_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] ar_q[$];
    wbeat_t      w_q[$];

    wb2axi4l_bridge dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .m_aw_addr  (m_aw_addr),
        .m_aw_prot  (m_aw_prot),
        .m_aw_valid (m_aw_valid),
        .m_aw_ready (m_aw_ready),
        .m_w_data   (m_w_data),
        .m_w_strb   (m_w_strb),
        .m_w_valid  (m_w_valid),
        .m_w_ready  (m_w_ready),
        .m_b_resp   (m_b_resp),
        .m_b_valid  (m_b_valid),
        .m_b_ready  (m_b_ready),
        .m_ar_addr  (m_ar_addr),
        .m_ar_prot  (m_ar_prot),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .m_r_data   (m_r_data),
        .m_r_resp   (m_r_resp),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // AXI4-Lite slave: readies and response valids appear after programmable waits.
    int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit  aw_done, w_done, b_pend, r_pend;

    assign m_aw_ready = m_aw_valid && (aw_cnt >= aw_dly);
    assign m_w_ready  = m_w_valid && (w_cnt >= w_dly);
    assign m_ar_ready = m_ar_valid && (ar_cnt >= ar_dly);
    assign m_b_valid  = b_pend && (b_cnt >= b_dly);
    assign m_r_valid  = r_pend && (r_cnt >= r_dly);
    assign m_b_resp   = b_resp_v;
    assign m_r_resp   = r_resp_v;
    assign m_r_data   = r_data_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_done <= 0; w_done <= 0; b_pend <= 0; r_pend <= 0;
        end else begin
            aw_cnt <= (m_aw_valid && !m_aw_ready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_w_valid && !m_w_ready) ? w_cnt + 1 : 0;
            ar_cnt <= (m_ar_valid && !m_ar_ready) ? ar_cnt + 1 : 0;
            if (b_pend) begin
                if (m_b_valid && m_b_ready) begin
                    b_pend <= 0;
                    b_cnt  <= 0;
                end else b_cnt <= b_cnt + 1;
            end else if ((aw_done || (m_aw_valid && m_aw_ready)) &&
                         (w_done || (m_w_valid && m_w_ready))) begin
                b_pend  <= 1;
                aw_done <= 0;
                w_done  <= 0;
            end else begin
                if (m_aw_valid && m_aw_ready) aw_done <= 1;
                if (m_w_valid && m_w_ready)   w_done  <= 1;
            end
            if (r_pend) begin
                if (m_r_valid && m_r_ready) begin
                    r_pend <= 0;
                    r_cnt  <= 0;
                end else r_cnt <= r_cnt + 1;
            end else if (m_ar_valid && m_ar_ready) r_pend <= 1;
        end
    end

    // Monitor, sampled on the falling edge.
    bit          p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r;
    logic [31:0] p_aw_a, p_w_d, p_ar_a;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_aw_v = 0; p_w_v = 0; p_ar_v = 0;
            p_aw_r = 0; p_w_r = 0; p_ar_r = 0;
        end else begin
            if (p_aw_v && !p_aw_r) begin
                chk("aw_valid_stable", m_aw_valid, 1);
                chk("aw_addr_stable", m_aw_addr, p_aw_a);
            end
            if (p_w_v && !p_w_r) begin
                chk("w_valid_stable", m_w_valid, 1);
                chk("w_data_stable", m_w_data, p_w_d);
            end
            if (p_ar_v && !p_ar_r) begin
                chk("ar_valid_stable", m_ar_valid, 1);
                chk("ar_addr_stable", m_ar_addr, p_ar_a);
            end
            if (m_aw_valid && m_aw_ready) begin
                if (aw_q.size() == 0) chk("aw_dup", 1, 0);
                else begin
                    chk("aw_addr", m_aw_addr, aw_q.pop_front());
                    chk("aw_prot", m_aw_prot, 0);
                end
            end
            if (m_w_valid && m_w_ready) begin
                if (w_q.size() == 0) chk("w_dup", 1, 0);
                else begin
                    wbeat_t wb;
                    wb = w_q.pop_front();
                    chk("w_data", m_w_data, wb.data);
                    chk("w_strb", m_w_strb, wb.strb);
                end
            end
            if (m_ar_valid && m_ar_ready) begin
                if (ar_q.size() == 0) chk("ar_dup", 1, 0);
                else begin
                    chk("ar_addr", m_ar_addr, ar_q.pop_front());
                    chk("ar_prot", m_ar_prot, 0);
                end
            end
            if (m_r_valid && m_r_ready) n_rhs++;
            if (wb_ack_o || wb_err_o) begin
                n_term++;
                if (sb_q.size() == 0) chk("wb_spurious_term", 1, 0);
                else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("wb_ack", wb_ack_o, !e.err);
                    chk("wb_err", wb_err_o, e.err);
                    chk("wb_dat", wb_dat_o, e.dat);
                    if (e.lat) chk("wb_latency", cyc_n - e.t0, 3);
                end
            end
            p_aw_v = m_aw_valid; p_aw_r = m_aw_ready; p_aw_a = m_aw_addr;
            p_w_v  = m_w_valid;  p_w_r  = m_w_ready;  p_w_d  = m_w_data;
            p_ar_v = m_ar_valid; p_ar_r = m_ar_ready; p_ar_a = m_ar_addr;
        end
    end

    task automatic wb_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit exp_err,
                          input logic [31:0] exp_rd, input bit lat);
        sb_t    e;
        wbeat_t wb;
        bit     done;
        @(posedge clk);
        #1;
        e.err = exp_err; e.dat = exp_rd; e.t0 = cyc_n; e.lat = lat;
        sb_q.push_back(e);
        if (we) begin
            aw_q.push_back(adr);
            wb.data = dat; wb.strb = sel;
            w_q.push_back(wb);
        end else ar_q.push_back(adr);
        wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        done = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o || wb_err_o) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("wb_timeout", 0, 1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    bit ok;
    int n0, r0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready,
                         m_r_ready, wb_ack_o, wb_err_o}, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_addr", m_aw_addr, 0);
        rst_n = 1'b1;

        // T1 zero-wait write with latency
        wb_req(1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1);

        // T2 read with slow R
        r_dly = 5; ar_dly = 2; r_data_v = 32'h12345678;
        wb_req(0, 32'h44, 32'h0, 4'h0, 0, 32'h12345678, 0);
        r_dly = 0; ar_dly = 0;

        // T3 W before AW, then AW before W
        w_dly = 0; aw_dly = 4; b_dly = 2;
        wb_req(1, 32'h50, 32'hA5A50001, 4'h3, 0, 32'h12345678, 0);
        w_dly = 4; aw_dly = 0;
        wb_req(1, 32'h54, 32'h5A5A0002, 4'hC, 0, 32'h12345678, 0);
        w_dly = 0; b_dly = 0;

        // sel=0 write to unaligned byte address
        wb_req(1, 32'h61, 32'h00000077, 4'h0, 0, 32'h12345678, 0);

        // T4 error responses
        r_resp_v = 2'b10; r_data_v = 32'hBADC0DE5;
        wb_req(0, 32'h58, 32'h0, 4'h0, 1, 32'hBADC0DE5, 0);
        r_resp_v = 2'b00;
        b_resp_v = 2'b11;
        wb_req(1, 32'h5C, 32'h1, 4'hF, 1, 32'hBADC0DE5, 0);
        b_resp_v = 2'b01;
        wb_req(1, 32'h60, 32'h2, 4'hF, 1, 32'hBADC0DE5, 0);
        b_resp_v = 2'b00;

        // T5 cyc dropped while waiting for R
        r_dly = 3; r_data_v = 32'h0BAD0BAD;
        @(posedge clk);
        #1;
        ar_q.push_back(32'h48);
        n0 = n_term; r0 = n_rhs;
        wb_we = 1'b0; wb_adr = 32'h48; wb_cyc = 1'b1; wb_stb = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (m_r_ready) begin
                ok = 1;
                break;
            end
        end
        chk("t5_rready_seen", ok, 1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_r_handshake", n_rhs - r0, 1);
        chk("t5_no_term", n_term - n0, 0);
        chk("t5_rready_low", m_r_ready, 0);
        r_dly = 0;

        r_data_v = 32'hCAFEF00D;
        wb_req(0, 32'h4C, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1);

        // T6 reset during WR_REQ
        aw_dly = 10; w_dly = 10;
        @(posedge clk);
        #1;
        wb_we = 1'b1; wb_adr = 32'h70; wb_dat = 32'h11223344; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (m_aw_valid) begin
                ok = 1;
                break;
            end
        end
        chk("t6_aw_valid", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready,
                               m_r_ready, wb_ack_o, wb_err_o}, 0);
        chk("t6_dat_clear", wb_dat_o, 0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        aw_dly = 0; w_dly = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle", {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready,
                        m_r_ready, wb_ack_o, wb_err_o}, 0);
        r_data_v = 32'h600DF00D;
        wb_req(0, 32'h74, 32'h0, 4'h0, 0, 32'h600DF00D, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        chk("aw_q_empty", aw_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);
        chk("ar_q_empty", ar_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
